// File: rtl/bcd_counter_multi.sv
`default_nettype none
// ============================================================================
// Module   : bcd_counter_multi
// Purpose  : DIGITS-decade up/down BCD counter with validated parallel load,
//            wrap/saturate terminal behaviour and per-digit carry outputs.
// Revision : 1.0  initial release
// ============================================================================
module bcd_counter_multi #(
    parameter int DIGITS = 2,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up_down,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic [DIGITS-1:0]     digit_carry,
    output logic                  done,
    output logic                  load_err
);

    logic [4*DIGITS-1:0] count_q;
    logic [4*DIGITS-1:0] count_d;
    logic                load_err_q;
    logic                load_err_d;

    logic [4*DIGITS-1:0] w_load_fix;
    logic [DIGITS-1:0]   w_is9;
    logic [DIGITS-1:0]   w_is0;
    logic [DIGITS-1:0]   w_bad;
    logic                w_terminal;
    logic                w_qual;
    logic                w_step;

    always_comb begin
        w_is9      = '0;
        w_is0      = '0;
        w_bad      = '0;
        w_load_fix = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_is9[i] = (count_q[4*i +: 4] == 4'd9);
            w_is0[i] = (count_q[4*i +: 4] == 4'd0);
            w_bad[i] = (load_value[4*i +: 4] > 4'd9);
            w_load_fix[4*i +: 4] = w_bad[i] ? 4'd0 : load_value[4*i +: 4];
        end
    end

    assign w_terminal = up_down ? (&w_is9) : (&w_is0);
    // Reset and load both pre-empt counting, so neither may report a step.
    assign w_qual     = enable & ~reset & ~load;
    assign w_step     = w_qual & (WRAP | ~w_terminal);
    assign done       = w_qual & w_terminal;

    // Ripple the "all lower digits at the rollover value" condition upward.
    always_comb begin
        logic       lower_ok;
        logic [3:0] d;
        lower_ok    = w_step;
        d           = 4'd0;
        digit_carry = '0;
        count_d     = count_q;
        for (int i = 0; i < DIGITS; i++) begin
            d = count_q[4*i +: 4];
            if (lower_ok) begin
                if (up_down) begin
                    digit_carry[i]    = w_is9[i];
                    count_d[4*i +: 4] = w_is9[i] ? 4'd0 : d + 4'd1;
                end else begin
                    digit_carry[i]    = w_is0[i];
                    count_d[4*i +: 4] = w_is0[i] ? 4'd9 : d - 4'd1;
                end
            end
            lower_ok = lower_ok & (up_down ? w_is9[i] : w_is0[i]);
        end
        if (load) begin
            count_d = w_load_fix;
        end
    end

    assign load_err_d = load & (|w_bad);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign load_err = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_counter_multi
// Purpose  : Self-checking bench for three counter variants driven in lockstep
//            (2-digit wrap, 2-digit saturate, 1-digit wrap).
// Revision : 1.0  initial release
// ============================================================================
module tb_bcd_counter_multi;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, enable, up_down, load;
    logic [7:0] load_value;

    logic [7:0] cnt_a, cnt_b;
    logic [3:0] cnt_c;
    logic [1:0] dc_a, dc_b;
    logic [0:0] dc_c;
    logic       dn_a, dn_b, dn_c;
    logic       le_a, le_b, le_c;

    bcd_counter_multi #(.DIGITS(2), .WRAP(1'b1)) u_a (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value), .count(cnt_a),
        .digit_carry(dc_a), .done(dn_a), .load_err(le_a));

    bcd_counter_multi #(.DIGITS(2), .WRAP(1'b0)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value), .count(cnt_b),
        .digit_carry(dc_b), .done(dn_b), .load_err(le_b));

    bcd_counter_multi #(.DIGITS(1), .WRAP(1'b1)) u_c (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value[3:0]), .count(cnt_c),
        .digit_carry(dc_c), .done(dn_c), .load_err(le_c));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int   k;
        int   nv;
        logic err;
    } exp_t;
    exp_t sb[$];

    int   m_val[3];
    bit   m_valid = 1'b0;

    function automatic int nd(int k);
        return (k == 2) ? 1 : 2;
    endfunction

    function automatic bit nw(int k);
        return (k != 1);
    endfunction

    function automatic int p10(int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [7:0] to_bcd(int v);
        logic [3:0] hi, lo;
        hi = 4'((v / 10) % 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic check(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    task automatic get_act(input int k, output logic [7:0] c, output logic [1:0] dc,
                           output logic dn, output logic le);
        case (k)
            0:       begin c = cnt_a; dc = dc_a; dn = dn_a; le = le_a; end
            1:       begin c = cnt_b; dc = dc_b; dn = dn_b; le = le_b; end
            default: begin c = {4'd0, cnt_c}; dc = {1'b0, dc_c}; dn = dn_c; le = le_c; end
        endcase
    endtask

    // One clock: drive, check combinational outputs, queue expected state, check after edge.
    task automatic cycle(input logic rst, input logic en, input logic ud,
                         input logic ld, input logic [7:0] lv);
        logic [7:0] ac;
        logic [1:0] adc, edc;
        logic       adn, ale, edn, term, e;
        int         v, maxv, nv, m, nib;
        exp_t       x;
        @(negedge clk);
        reset = rst; enable = en; up_down = ud; load = ld; load_value = lv;
        #1;
        for (int k = 0; k < 3; k++) begin
            v    = m_val[k];
            maxv = p10(nd(k)) - 1;
            term = ud ? (v == maxv) : (v == 0);
            edn  = !rst && !ld && en && term;
            edc  = 2'b00;
            if (!rst && !ld && en && !(term && !nw(k))) begin
                for (int i = 0; i < nd(k); i++) begin
                    m = p10(i + 1);
                    edc[i] = ud ? ((v % m) == m - 1) : ((v % m) == 0);
                end
            end
            if (m_valid) begin
                get_act(k, ac, adc, adn, ale);
                check("done", k, {7'd0, adn}, {7'd0, edn});
                check("digit_carry", k, {6'd0, adc}, {6'd0, edc});
            end
            e = 1'b0;
            if (rst) begin
                nv = 0;
            end else if (ld) begin
                nv = 0;
                for (int i = 0; i < nd(k); i++) begin
                    nib = int'(lv[4*i +: 4]);
                    if (nib > 9) begin nib = 0; e = 1'b1; end
                    nv += nib * p10(i);
                end
            end else if (en) begin
                if (ud) nv = term ? (nw(k) ? 0 : v) : v + 1;
                else    nv = term ? (nw(k) ? maxv : v) : v - 1;
            end else begin
                nv = v;
            end
            x.k = k; x.nv = nv; x.err = e;
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            get_act(x.k, ac, adc, adn, ale);
            check("count", x.k, ac, to_bcd(x.nv));
            check("load_err", x.k, {7'd0, ale}, {7'd0, x.err});
            m_val[x.k] = x.nv;
        end
        m_valid = 1'b1;
    endtask

    typedef struct {
        logic       rst, en, ud, ld;
        logic [7:0] lv;
        logic [7:0] exp_cnt;
        logic       exp_err;
    } vec_t;

    vec_t vecs[12];

    initial begin
        reset = 1'b1; enable = 1'b0; up_down = 1'b1; load = 1'b0; load_value = 8'h00;
        m_val[0] = 0; m_val[1] = 0; m_val[2] = 0;

        // Table of load/reset/hold corner cases with literal expectations for the 2-digit wrap counter.
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h1A, 8'h10, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h10, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h42, 8'h42, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h57, 8'h57, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h58, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h9F, 8'h90, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 8'h00, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0};

        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        check("reset_count", 0, cnt_a, 8'h00);

        // Full up sweep 00..99..00 with wrap; 1-digit instance runs its 0-9 loop alongside.
        for (int n = 0; n < 105; n++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
            if (n < 15) check("legacy_seq", 2, {4'd0, cnt_c}, 8'((n + 1) % 10));
        end

        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].rst, vecs[i].en, vecs[i].ud, vecs[i].ld, vecs[i].lv);
            check("vec_count", i, cnt_a, vecs[i].exp_cnt);
            check("vec_load_err", i, {7'd0, le_a}, {7'd0, vecs[i].exp_err});
        end

        // Down from 00 wraps to 99, then through 90->89.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int n = 0; n < 12; n++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("down_wrap_end", 0, cnt_a, 8'h88);

        // Saturation: 98 -> 99, hold, then reverse.
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h98);
        for (int n = 0; n < 6; n++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        check("sat_hold", 1, cnt_b, 8'h99);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("sat_reverse", 1, cnt_b, 8'h98);
        for (int n = 0; n < 100; n++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("sat_floor", 1, cnt_b, 8'h00);

        // Mixed random traffic, including direction flips and invalid loads.
        for (int n = 0; n < 300; n++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 5) != 0), ($urandom_range(0, 15) == 0),
                  8'($urandom_range(0, 255)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
